// File: rtl/ibex_defines.sv
// Shared widths for the instruction prefetch path.
// Fetch FIFO entries carry one 32-bit word plus its bus error bit.
package ibex_defines;

   localparam int unsigned IBEX_WORD_W         = 32;
   localparam int unsigned IBEX_FIFO_ENTRY_W   = IBEX_WORD_W + 1;
   localparam int unsigned IBEX_FIFO_MAX_WORDS = 8;
   localparam int unsigned IBEX_FIFO_CNT_W     = $clog2(IBEX_FIFO_MAX_WORDS + 1);

endpackage

// File: rtl/ibex_fetch_fifo.sv
// Circular word FIFO for fetched instructions: one push, zero or one pop
// per cycle, with the head and the entry behind it visible for realignment.
module ibex_fetch_fifo
   import ibex_defines::*;
#(
   parameter int unsigned NumWords = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [IBEX_FIFO_ENTRY_W-1:0] push_data_i,
   input  logic                         pop_i,
   output logic [IBEX_FIFO_ENTRY_W-1:0] head_o,
   output logic                         head_valid_o,
   output logic [IBEX_FIFO_ENTRY_W-1:0] next_o,
   output logic                         next_valid_o,
   output logic [IBEX_FIFO_CNT_W-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(NumWords);
   localparam int unsigned CntW = IBEX_FIFO_CNT_W;

   logic [IBEX_FIFO_ENTRY_W-1:0] mem_q [NumWords];
   logic [PtrW-1:0]              rd_ptr_q;
   logic [PtrW-1:0]              wr_ptr_q;
   logic [CntW-1:0]              count_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(NumWords - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign head_o       = mem_q[rd_ptr_q];
   assign next_o       = mem_q[ptr_inc(rd_ptr_q)];
   assign head_valid_o = (count_q != '0);
   assign next_valid_o = (count_q > CntW'(1));
   assign count_o      = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < NumWords; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   // Request throttling keeps fifo_count + outstanding <= NumWords.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         assert (!(push_i && !pop_i && count_q == CntW'(NumWords)));
         assert (!(pop_i && count_q == '0));
      end
   end

endmodule

// File: rtl/ibex_prefetch_align_buffer.sv
// IF-stage prefetch buffer with halfword realignment: parcels starting at
// PC[1]=1 or straddling a word boundary leave as one 32-bit instruction.
module ibex_prefetch_align_buffer
   import ibex_defines::*;
#(
   parameter int unsigned NumWords       = 3,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        busy_o
);

   localparam int unsigned CntW = IBEX_FIFO_CNT_W;
   localparam int unsigned OccW = CntW + 1;

   logic [31:2]     fetch_addr_q, fetch_addr_d;
   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [CntW-1:0] discard_q, discard_d;
   logic [31:1]     pc_q, pc_d;
   logic            half_off_q, half_off_d;
   logic            active_q, active_d;

   logic [IBEX_FIFO_ENTRY_W-1:0] head, nxt;
   logic                         head_vld, nxt_vld;
   logic [CntW-1:0]              fifo_cnt;
   logic [31:0]                  h_data, n_data;
   logic                         h_err, n_err;

   logic [OccW-1:0] occupancy;
   logic            gnt_fire, push, pop, fire, compressed;
   logic            unused_bits;

   assign h_data = head[IBEX_FIFO_ENTRY_W-1:1];
   assign h_err  = head[0];
   assign n_data = nxt[IBEX_FIFO_ENTRY_W-1:1];
   assign n_err  = nxt[0];

   assign unused_bits = ^{branch_addr_i[0], n_data[31:16]};

   assign occupancy   = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
   assign instr_req_o = req_i & ~branch_i & active_q
                      & (outstanding_q < CntW'(MaxOutstanding))
                      & (occupancy < OccW'(NumWords));
   assign instr_addr_o = {fetch_addr_q, 2'b00};
   assign gnt_fire     = instr_req_o & instr_gnt_i;
   assign busy_o       = instr_req_o | (outstanding_q != '0);

   // Responses that belong to a flushed stream never reach the FIFO.
   assign push = instr_rvalid_i & ~branch_i & (discard_q == '0);

   ibex_fetch_fifo #(
      .NumWords (NumWords)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (branch_i),
      .push_i       (push),
      .push_data_i  ({instr_rdata_i, instr_err_i}),
      .pop_i        (pop),
      .head_o       (head),
      .head_valid_o (head_vld),
      .next_o       (nxt),
      .next_valid_o (nxt_vld),
      .count_o      (fifo_cnt)
   );

   always_comb begin
      compressed = 1'b0;
      valid_o    = 1'b0;
      rdata_o    = h_data;
      err_o      = h_err;
      if (!half_off_q) begin
         compressed = (h_data[1:0] != 2'b11);
         valid_o    = head_vld;
      end else begin
         compressed = (h_data[17:16] != 2'b11);
         rdata_o    = {n_data[15:0], h_data[31:16]};
         if (compressed) begin
            valid_o = head_vld;
         end else begin
            // An erroring head is delivered without waiting for its partner.
            valid_o = head_vld & (nxt_vld | h_err);
            err_o   = h_err | (nxt_vld & n_err);
         end
      end
   end

   assign addr_o = {pc_q, 1'b0};
   assign fire   = valid_o & ready_i & ~branch_i;
   assign pop    = fire & (half_off_q | ~compressed);

   always_comb begin
      fetch_addr_d  = fetch_addr_q;
      outstanding_d = outstanding_q + CntW'(gnt_fire) - CntW'(instr_rvalid_i);
      discard_d     = discard_q;
      pc_d          = pc_q;
      half_off_d    = half_off_q;
      active_d      = active_q | branch_i;
      if (branch_i) begin
         fetch_addr_d = branch_addr_i[31:2];
         discard_d    = outstanding_d;
         pc_d         = branch_addr_i[31:1];
         half_off_d   = branch_addr_i[1];
      end else begin
         if (gnt_fire) begin
            fetch_addr_d = fetch_addr_q + 30'd1;
         end
         if (instr_rvalid_i && discard_q != '0) begin
            discard_d = discard_q - CntW'(1);
         end
         if (fire) begin
            pc_d       = pc_q + (compressed ? 31'd1 : 31'd2);
            half_off_d = half_off_q ^ compressed;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr_q  <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         pc_q          <= '0;
         half_off_q    <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         fetch_addr_q  <= fetch_addr_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         pc_q          <= pc_d;
         half_off_q    <= half_off_d;
         active_q      <= active_d;
      end
   end

endmodule

// File: tb/tb_ibex_prefetch_align_buffer.sv
// Scoreboard bench for the realigning prefetch buffer with a simple
// one-cycle-latency instruction memory model.
module tb_ibex_prefetch_align_buffer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] rdata_o;
   logic [31:0] addr_o;
   logic        err_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
      logic        err;
   } want_t;

   want_t want_q[$];

   logic [31:0] mem  [logic [31:0]];
   logic        errm [logic [31:0]];
   logic [31:0] pend [$];
   bit          hold = 1'b0;

   ibex_prefetch_align_buffer #(
      .NumWords       (3),
      .MaxOutstanding (3)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .ready_i        (ready_i),
      .valid_o        (valid_o),
      .rdata_o        (rdata_o),
      .addr_o         (addr_o),
      .err_o          (err_o),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .busy_o         (busy_o)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic want(input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] m, input logic e);
      want_t w;
      w.addr = a;
      w.data = d;
      w.mask = m;
      w.err  = e;
      want_q.push_back(w);
   endtask

   task automatic do_branch(input logic [31:0] a);
      branch_i      = 1'b1;
      branch_addr_i = a;
      tick();
      branch_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (want_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (want_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending expected 0",
                  want_q.size());
         want_q.delete();
      end
      ready_i = 1'b0;
   endtask

   // Memory: grants sampled mid-cycle, data returned the following cycle.
   initial begin : memmodel
      logic        nv, ne;
      logic [31:0] nd, a;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
      forever begin
         @(negedge clk);
         nv = 1'b0;
         nd = '0;
         ne = 1'b0;
         if (rst_i) begin
            pend.delete();
         end else begin
            if (instr_req_o && instr_gnt_i) pend.push_back(instr_addr_o);
            if (!hold && pend.size() != 0) begin
               a  = pend.pop_front();
               nv = 1'b1;
               nd = mem.exists(a) ? mem[a] : 32'h0000_0013;
               ne = errm.exists(a) ? errm[a] : 1'b0;
            end
         end
         @(posedge clk);
         #1;
         instr_rvalid_i = nv;
         instr_rdata_i  = nd;
         instr_err_i    = ne;
      end
   end

   always @(negedge clk) begin : monitor
      want_t w;
      if (!rst_i && valid_o && ready_i && !branch_i) begin
         if (want_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got addr %h expected none",
                     addr_o);
         end else begin
            w = want_q.pop_front();
            chk("out_addr", addr_o, w.addr);
            chk("out_rdata", rdata_o & w.mask, w.data);
            chk("out_err", 32'(err_o), 32'(w.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int g;
      rst_i         = 1'b1;
      req_i         = 1'b0;
      branch_i      = 1'b0;
      branch_addr_i = '0;
      ready_i       = 1'b0;
      instr_gnt_i   = 1'b0;
      tick();
      tick();
      neg();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_iaddr", instr_addr_o, 32'h0);
      chk("rst_addr", addr_o, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_err", 32'(err_o), 32'd0);
      tick();
      rst_i       = 1'b0;
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      neg();
      chk("idle_no_req0", 32'(instr_req_o), 32'd0);
      tick();
      neg();
      chk("idle_no_req1", 32'(instr_req_o), 32'd0);

      // Branch latency and sequential fetch addresses
      tick();
      mem[32'h80] = 32'h0000_0013;
      do_branch(32'h80);
      neg();
      chk("t1_req", 32'(instr_req_o), 32'd1);
      chk("t1_iaddr0", instr_addr_o, 32'h80);
      chk("t1_valid_t1", 32'(valid_o), 32'd0);
      tick();
      neg();
      chk("t1_iaddr1", instr_addr_o, 32'h84);
      chk("t1_valid_t2", 32'(valid_o), 32'd0);
      tick();
      neg();
      chk("t1_valid_t3", 32'(valid_o), 32'd1);
      chk("t1_addr", addr_o, 32'h80);
      chk("t1_rdata", rdata_o, 32'h0000_0013);
      chk("t1_err", 32'(err_o), 32'd0);
      chk("t1_iaddr2", instr_addr_o, 32'h88);

      // Two compressed parcels in one word, one pop
      tick();
      mem[32'h100] = 32'h4501_4501;
      mem[32'h104] = 32'h0000_0513;
      mem[32'h108] = 32'h0010_0093;
      want(32'h100, 32'h4501, 32'hFFFF, 1'b0);
      want(32'h102, 32'h4501, 32'hFFFF, 1'b0);
      want(32'h104, 32'h0000_0513, 32'hFFFF_FFFF, 1'b0);
      want(32'h108, 32'h0010_0093, 32'hFFFF_FFFF, 1'b0);
      ready_i = 1'b1;
      do_branch(32'h100);
      drain();

      // Straddling uncompressed parcel at PC[1]=1
      mem[32'h100] = 32'h0013_0000;
      mem[32'h104] = 32'hABCD_0000;
      mem[32'h108] = 32'h0000_0013;
      want(32'h102, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
      want(32'h106, 32'hABCD, 32'hFFFF, 1'b0);
      want(32'h108, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
      ready_i = 1'b1;
      do_branch(32'h102);
      neg();
      tick();
      neg();
      chk("t3_wait_first", 32'(valid_o), 32'd0);
      tick();
      neg();
      chk("t3_wait_second", 32'(valid_o), 32'd0);
      tick();
      neg();
      chk("t3_valid", 32'(valid_o), 32'd1);
      drain();

      // Capacity limit with a stalled consumer
      do_branch(32'h400);
      g = 0;
      for (int i = 0; i < 10; i++) begin
         neg();
         if (instr_req_o && instr_gnt_i) g++;
         tick();
      end
      chk("t4_grants", 32'(g), 32'd3);
      neg();
      chk("t4_req_full", 32'(instr_req_o), 32'd0);
      chk("t4_busy_full", 32'(busy_o), 32'd0);
      tick();
      want(32'h400, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
      ready_i = 1'b1;
      neg();
      tick();
      ready_i = 1'b0;
      g = 0;
      for (int i = 0; i < 10; i++) begin
         neg();
         if (instr_req_o && instr_gnt_i) g++;
         tick();
      end
      chk("t4_refill_grants", 32'(g), 32'd1);

      // Outstanding limit with responses held back
      hold = 1'b1;
      do_branch(32'h500);
      g = 0;
      for (int i = 0; i < 8; i++) begin
         neg();
         if (instr_req_o && instr_gnt_i) g++;
         tick();
      end
      chk("t4b_grants", 32'(g), 32'd3);
      neg();
      chk("t4b_req", 32'(instr_req_o), 32'd0);
      chk("t4b_busy", 32'(busy_o), 32'd1);
      tick();
      hold = 1'b0;
      repeat (4) tick();

      // Stale responses discarded after a branch
      mem[32'h600] = 32'hDEAD_BEEF;
      mem[32'h604] = 32'hDEAD_BEEF;
      mem[32'h200] = 32'h0020_0093;
      hold = 1'b1;
      do_branch(32'h600);
      neg();
      tick();
      neg();
      tick();
      instr_gnt_i = 1'b0;
      neg();
      chk("t5_busy", 32'(busy_o), 32'd1);
      chk("t5_req_pending", 32'(instr_req_o), 32'd1);
      tick();
      hold = 1'b0;
      neg();
      tick();
      instr_gnt_i = 1'b1;
      want(32'h200, 32'h0020_0093, 32'hFFFF_FFFF, 1'b0);
      want(32'h204, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
      ready_i = 1'b1;
      do_branch(32'h200);
      drain();

      // Erroring head delivered alone
      mem[32'h300]  = 32'h0013_0000;
      errm[32'h300] = 1'b1;
      do_branch(32'h302);
      neg();
      tick();
      instr_gnt_i = 1'b0;
      neg();
      tick();
      want(32'h302, 32'h0013, 32'hFFFF, 1'b1);
      ready_i = 1'b1;
      neg();
      chk("t6_valid", 32'(valid_o), 32'd1);
      chk("t6_err", 32'(err_o), 32'd1);
      chk("t6_addr", addr_o, 32'h302);
      tick();
      ready_i = 1'b0;
      neg();
      chk("t6_empty", 32'(valid_o), 32'd0);
      tick();

      // Error on the second word of a straddling parcel
      instr_gnt_i   = 1'b1;
      mem[32'h700]  = 32'h0013_0000;
      mem[32'h704]  = 32'hABCD_0000;
      errm[32'h704] = 1'b1;
      want(32'h702, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1);
      want(32'h706, 32'hABCD, 32'hFFFF, 1'b1);
      want(32'h708, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
      ready_i = 1'b1;
      do_branch(32'h702);
      drain();

      // Reset with requests in flight
      hold = 1'b1;
      do_branch(32'h800);
      tick();
      neg();
      chk("t8_busy", 32'(busy_o), 32'd1);
      tick();
      rst_i = 1'b1;
      tick();
      neg();
      chk("t8_valid", 32'(valid_o), 32'd0);
      chk("t8_req", 32'(instr_req_o), 32'd0);
      chk("t8_busy_rst", 32'(busy_o), 32'd0);
      chk("t8_iaddr", instr_addr_o, 32'h0);
      chk("t8_addr", addr_o, 32'h0);
      tick();
      rst_i = 1'b0;
      hold  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("t8_post_req", 32'(instr_req_o), 32'd0);
         chk("t8_post_valid", 32'(valid_o), 32'd0);
         tick();
      end

      chk("final_queue_empty", 32'(want_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibex_prefetch_align_buffer.md
Name: ibex_prefetch_align_buffer

Overview:
Next-generation instruction prefetch buffer for the IF stage, replacing the fixed prefetch buffer.
- Parametrised FIFO depth and maximum outstanding bus transactions.
- Fetch-error propagation.
- Halfword realignment, so branch targets at PC[1]=1 and uncompressed instructions straddling a word boundary are delivered as one 32-bit parcel.
- Sits between the instruction memory interface and the compressed decoder / IF-ID registers.

Parameters:
- NumWords, 3, FIFO depth in 32-bit words; legal values are 2 to 8.
- MaxOutstanding, 2, maximum granted-but-unanswered requests; legal values are 1 to NumWords.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  fetch enable
- branch_i  in  1  flush and restart at branch_addr_i
- branch_addr_i  in  32  new PC; bit 0 ignored
- ready_i  in  1  consumer accepts the current instruction
- valid_o  out  1  rdata_o/addr_o/err_o are valid
- rdata_o  out  32  instruction; compressed instructions occupy [15:0], [31:16] is don't-care
- addr_o  out  32  PC of rdata_o, halfword aligned
- err_o  out  1  bus error on any word contributing to rdata_o
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  word-aligned request address
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response error, qualified by rvalid
- busy_o  out  1  requests outstanding or pending

Behaviour:
Reset (rst_i sampled high at a clock edge):
- All outputs are 0 and instr_addr_o=0.
- FIFO is empty; outstanding and discard counters are 0.
- No requests are issued until the first branch_i.
- Reset mid-transaction abandons in-flight responses; the memory side is reset in the same cycle.

Request side:
- instr_req_o = req_i & ~branch_i & (outstanding < MaxOutstanding) & (fifo_count + outstanding < NumWords).
- instr_addr_o = fetch_addr. fetch_addr advances by 4 on every instr_req_o&instr_gnt_i; outstanding increments at the same time.
- instr_rvalid_i decrements outstanding. Same-cycle gnt and rvalid leave the count unchanged.

Branch:
- In the branch_i cycle: fetch_addr<={branch_addr_i[31:2],2'b00}, half_off<=branch_addr_i[1], FIFO is flushed, discard_cnt<=outstanding (+1 if a grant occurs that cycle), instr_req_o=0.
- Every rvalid while discard_cnt>0 is dropped and decrements discard_cnt.
- branch_i overrides same-cycle ready_i, which is ignored, and same-cycle rvalid, which is counted as discarded.
- Branch to (current_addr+4) still flushes.

Push:
- A non-discarded rvalid writes {rdata, err} to the FIFO tail.
- Overflow is impossible by construction; assert it.

Output (combinational from FIFO head; no bypass):
- valid_o is earliest one cycle after the rvalid that completes the parcel.
- Branch in cycle T with gnt=1 and rvalid one cycle after grant gives valid_o in cycle T+3.
- half_off=0: parcel is head[15:0]. Compressed if [1:0]!=2'b11 and needs 1 word. Uncompressed needs 1 word and rdata_o=head.
- half_off=1: parcel starts at head[31:16]. Compressed if head[17:16]!=2'b11 and needs 1 word. Uncompressed needs 2 words and rdata_o={head+1[15:0], head[31:16]}.
- err_o = OR of the error bits of the words used. When head has err=1, valid_o=1 is raised after head alone, even if a second word is needed.
- addr_o = {pc_q[31:1],1'b0}, where pc_q is loaded from branch_addr_i.

Consume (valid_o&ready_i):
- pc_q increments by 2 (compressed) or 4.
- Word pops follow the new halfword offset: compressed at off 0 pops 0 words and sets off=1; compressed at off 1 pops 1 and sets off=0; uncompressed at off 0 pops 1; uncompressed at off 1 pops 1 and keeps off=1.
- Push and pop in the same cycle are legal at full and at empty.

busy_o = instr_req_o | (outstanding!=0).

Decomposition:
- Shared package ibex_defines gains localparam-derived widths only; no new enums.
- Sub-module ibex_fetch_fifo holds NumWords x 33-bit storage with count and flush, pushes 1 word, pops 0–1 words per cycle, and exposes head and head+1 with their valid bits.
- Alignment, counters and request logic stay in the top module.

Test Plan:
- Reset; branch_i to 0x80; gnt=1 always, rvalid one cycle after grant, data 0x00000013 -> valid_o=1 in cycle T+3 with addr_o=0x80, rdata_o=0x00000013, err_o=0; next instr_addr_o is 0x84, 0x88.
- Word 0x45014501 at 0x100, ready_i=1 -> two outputs: addr_o 0x100 then 0x102, both rdata_o[15:0]=0x4501; exactly one FIFO pop.
- Branch to 0x102; words 0x00130000@0x100 and 0xABCD0000@0x104 -> single output with addr_o=0x102, rdata_o=0x00000013, issued only after the second rvalid; next addr_o=0x106.
- NumWords=3, MaxOutstanding=3, ready_i=0 -> exactly 3 grants, then instr_req_o=0; after one consume, exactly one more request.
- Two outstanding, branch_i to 0x200 -> both stale rvalids are dropped; first valid_o has addr_o=0x200 and new data.
- rvalid with instr_err_i=1 for 0x300, branch target 0x302 with an uncompressed parcel -> valid_o=1, err_o=1, addr_o=0x302 without waiting for 0x304.
